// File: rtl/dmem_responder.sv
// Single-port data memory responder with fixed access latency.
// Accepts one request, waits LATENCY cycles, then holds a response until
// it is consumed. Misaligned, illegal-size and out-of-range accesses fault.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Storage is never reset; contents are undefined until written.
    logic [31:0] mem [DEPTH_WORDS];

    logic          do_access, fault, wr_en;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword, rword, rshift, load_val;

    // Fault detection, byte-lane enables and load extraction on captured request
    always_comb begin
        idx    = addr_q[AW+1:2];
        rword  = mem[idx];
        fault  = (size_q == 2'b11)
               || (size_q == 2'b01 && addr_q[0])
               || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
               || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        be       = 4'b1111;
        wword    = wdata_q;
        rshift   = rword;
        load_val = rword;
        case (size_q)
            2'b00: begin
                be       = 4'b0001 << addr_q[1:0];
                wword    = {4{wdata_q[7:0]}};
                rshift   = rword >> {addr_q[1:0], 3'b000};
                load_val = uns_q ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                be       = addr_q[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata_q[15:0]}};
                rshift   = rword >> {addr_q[1], 4'b0000};
                load_val = uns_q ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            end
            default: ;
        endcase
        do_access = (state_q == S_WAIT) && (cnt_q == 4'd0);
        wr_en     = do_access && we_q && !fault;
    end

    // Byte-lane store; a reset on the access edge drops the write
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wword[b*8 +: 8];
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state, latency counter, request capture and response latch
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = fault;
                    rdata_d = (fault || we_q) ? 32'h0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Returning to IDLE here means the next accept is one edge later.
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a byte-array model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [DEPTH*4];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: little-endian byte memory, faults from the access rules
    function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [1:0] sz, input logic uns,
                                  output logic [31:0] rd, output logic err);
        int nb;
        rd  = 32'h0;
        err = 1'b0;
        if (sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a / 4 >= DEPTH)) begin
            err = 1'b1;
            return;
        end
        nb = 1 << sz;
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_mem[a + i];
            if (!uns && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8*nb)) - 32'd1);
        end
    endfunction

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = uns; resp_ready = 1'b0;
        @(negedge clk);
        // Scramble inputs so a late capture would show up
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = ~uns;
        resp_ready = (hold == 0);
        model(we, a, wd, sz, uns, exp_rd, exp_err);
        n = 0;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, LAT);
        chk("rdata", resp_rdata, exp_rd);
        chk("err", {31'h0, resp_err}, {31'h0, exp_err});
        chk("busy_ready", req_ready, 0);
        got_rd  = resp_rdata;
        got_err = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", resp_valid, 1);
            chk("hold_rdata", resp_rdata, exp_rd);
            chk("hold_err", {31'h0, resp_err}, {31'h0, exp_err});
            chk("hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("post_valid", resp_valid, 0);
        chk("post_ready", req_ready, 1);
    endtask

    task automatic rand_fields();
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
        req_addr     = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 + 7));
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er, eer;
        logic [31:0] q_rd[$];
        logic        q_err[$];
        int          acc, nresp, cyc, last;
        logic        reload;

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b0;

        for (int w = 0; w < DEPTH; w++) do_req(1'b1, 32'(w*4), $urandom, 2'd2, 1'b0, 0, rd, er);

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, rd, er);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
        chk("word_load", rd, 32'hDEADBEEF);
        do_req(1'b1, 32'h11, 32'h80, 2'd0, 1'b0, 0, rd, er);
        do_req(1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 0, rd, er);
        chk("byte_signed", rd, 32'hFFFFFF80);
        do_req(1'b0, 32'h11, 32'h0, 2'd0, 1'b1, 0, rd, er);
        chk("byte_unsigned", rd, 32'h00000080);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 0, rd, er);
        chk("word_after_byte", rd, 32'hDEAD80EF);
        do_req(1'b1, 32'h13, 32'h1234, 2'd1, 1'b0, 0, rd, er);
        chk("misaligned_err", er, 1);
        chk("misaligned_rdata", rd, 0);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, rd, er);
        chk("word_unchanged", rd, 32'hDEAD80EF);
        do_req(1'b0, 32'(DEPTH*4), 32'h0, 2'd2, 1'b0, 0, rd, er);
        chk("range_err", er, 1);
        do_req(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, rd, er);

        // Reset mid-wait on a pending byte store
        do_req(1'b1, 32'h20, 32'h0, 2'd2, 1'b0, 0, rd, er);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("wrst_valid", resp_valid, 0);
        chk("wrst_ready", req_ready, 1);
        chk("wrst_rdata", resp_rdata, 0);
        chk("wrst_err", resp_err, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wrst_no_resp", resp_valid, 0);
        end
        resp_ready = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 2'd0, 1'b1, 0, rd, er);
        chk("rst_store_dropped", rd, 0);

        // Back-to-back with both valids held high
        acc = 0; nresp = 0; cyc = 0; last = -1; reload = 1'b0;
        @(negedge clk);
        rand_fields();
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        while ((acc < 8 || nresp < 8) && cyc < 400) begin
            if (reload) begin
                if (acc < 8) rand_fields(); else req_valid = 1'b0;
                reload = 1'b0;
            end
            if (resp_valid) begin
                if (q_rd.size() == 0) begin
                    chk("b2b_spurious", 1, 0);
                end else begin
                    erd = q_rd.pop_front();
                    eer = q_err.pop_front();
                    chk("b2b_rdata", resp_rdata, erd);
                    chk("b2b_err", {31'h0, resp_err}, {31'h0, eer});
                end
                nresp++;
            end
            if (req_ready && req_valid) begin
                if (last >= 0) chk("b2b_interval", cyc - last, LAT + 2);
                last = cyc;
                model(req_we, req_addr, req_wdata, req_size, req_unsigned, erd, eer);
                q_rd.push_back(erd);
                q_err.push_back(eer);
                acc++;
                reload = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b_accepts", acc, 8);
        chk("b2b_responses", nresp, 8);
        req_valid  = 1'b0;
        resp_ready = 1'b0;

        for (int t = 0; t < 300; t++) begin
            rand_fields();
            do_req(req_we, req_addr, req_wdata, req_size, req_unsigned,
                   ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0, rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
